// File: rtl/unaligned_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : unaligned_mem_ctrl
// Description : Byte-addressed memory controller that accepts byte, halfword
//               and word accesses at any alignment. It fronts an internal
//               DEPTH x DATA_W synchronous RAM with byte lanes. An access that
//               crosses a word boundary touches words A and A+1, and A+1 wraps
//               modulo DEPTH. Writes are read-modify-write sequences.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1       clock, rising edge
//   rst    in   1       asynchronous active-high reset
//   req    in   1       request strobe, sampled only while busy=0
//   we     in   1       1=write, 0=read
//   size   in   2       0=byte, 1=halfword, 2=word, 3=reserved (error)
//   addr   in   ADDR_W  byte address, any alignment
//   wdata  in   DATA_W  write data, LSB-aligned
//   sext   in   1       sign-extend byte/halfword reads (MEM_SIGN_EXT_EN only)
//   rdata  out  DATA_W  read data, LSB-aligned, held until the next read
//   busy   out  1       high from the accept edge until the edge after done
//   done   out  1       one-cycle completion pulse
//   err    out  1       one-cycle pulse with done for size=3
// Configuration macro
//   MEM_SIGN_EXT_EN : adds the sext input; without it narrow reads zero-extend
// ============================================================================
module unaligned_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2**(ADDR_W-$clog2(DATA_W/8))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_SIGN_EXT_EN
  input  logic              sext,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BYTES  = DATA_W/8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int NB_W   = OFF_W+1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WB     = 2*BYTES;
  localparam int WIDE_W = 2*DATA_W;
  localparam int SH_W   = OFF_W+3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    MRG  = 3'd3,
    WRA  = 3'd4,
    WRB  = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_a_q;
  logic [IDX_W-1:0]  idx_b_q;
  logic [OFF_W-1:0]  off_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              span_q;
  logic              sext_q;
  logic [DATA_W-1:0] word_a_q;
  logic [DATA_W-1:0] new_a_q;
  logic [DATA_W-1:0] new_b_q;
  logic [BYTES-1:0]  be_a_q;
  logic [BYTES-1:0]  be_b_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // RAM storage and its registered read port
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_dout_q;

  // --------------------------------------------------------------------------
  // Accept-time decode of the incoming request
  // --------------------------------------------------------------------------
  logic [OFF_W-1:0] w_off;
  logic [NB_W-1:0]  w_nbytes;
  logic             w_span;
  logic [IDX_W-1:0] w_idx_a;
  logic [IDX_W-1:0] w_idx_b;
  logic             w_sext;

  assign w_off   = addr[OFF_W-1:0];
  assign w_idx_a = IDX_W'(addr[ADDR_W-1:OFF_W]);
  // The second word of a spanning access wraps to word 0 past the top
  assign w_idx_b = (w_idx_a == IDX_W'(DEPTH-1)) ? '0 : w_idx_a + 1'b1;
  assign w_span  = ({1'b0, w_off} + w_nbytes) > NB_W'(BYTES);

`ifdef MEM_SIGN_EXT_EN
  assign w_sext = sext;
`else
  assign w_sext = 1'b0;
`endif

  always_comb begin
    w_nbytes = NB_W'(BYTES);
    case (size)
      2'd0:    w_nbytes = NB_W'(1);
      2'd1:    w_nbytes = NB_W'(2);
      default: w_nbytes = NB_W'(BYTES);
    endcase
  end

  // --------------------------------------------------------------------------
  // Merge datapath: works on the two-word window {word A+1, word A}
  // --------------------------------------------------------------------------
  logic [BYTES-1:0]  w_lanes;
  logic [DATA_W-1:0] w_size_bitmask;
  logic [WB-1:0]     w_mask_wide;
  logic [WIDE_W-1:0] w_bitmask;
  logic [WIDE_W-1:0] w_wide;
  logic [SH_W-1:0]   w_shift;
  logic [WIDE_W-1:0] w_wdata_wide;
  logic [WIDE_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_shift;
  logic [DATA_W-1:0] w_rd_raw;
  logic              w_sign;
  logic [DATA_W-1:0] w_rd_final;

  always_comb begin
    w_lanes = '1;
    case (size_q)
      2'd0:    w_lanes = BYTES'(1);
      2'd1:    w_lanes = BYTES'(3);
      default: w_lanes = '1;
    endcase
  end

  generate
    for (genvar i = 0; i < BYTES; i++) begin : g_size_mask
      assign w_size_bitmask[8*i +: 8] = {8{w_lanes[i]}};
    end
    for (genvar i = 0; i < WB; i++) begin : g_wide_mask
      assign w_bitmask[8*i +: 8] = {8{w_mask_wide[i]}};
    end
  endgenerate

  assign w_shift      = {off_q, 3'b000};
  assign w_mask_wide  = WB'(w_lanes) << off_q;
  // Non-spanning accesses live entirely in the RAM output word; a spanning
  // access has word A parked in word_a_q while word A+1 arrives on the port
  assign w_wide       = span_q ? {ram_dout_q, word_a_q} : WIDE_W'(ram_dout_q);
  assign w_wdata_wide = WIDE_W'(wdata_q & w_size_bitmask) << w_shift;
  assign w_merged     = (w_wide & ~w_bitmask) | (w_wdata_wide & w_bitmask);
  assign w_rd_shift   = DATA_W'(w_wide >> w_shift);
  assign w_rd_raw     = w_rd_shift & w_size_bitmask;
  assign w_sign       = (size_q == 2'd0) ? w_rd_raw[7] : w_rd_raw[15];
  assign w_rd_final   = (sext_q && (size_q != 2'd2) && w_sign) ?
                        (w_rd_raw | ~w_size_bitmask) : w_rd_raw;

  // --------------------------------------------------------------------------
  // RAM port control: write enables exist only in WRA/WRB, so a reset that
  // returns the FSM to IDLE also removes any pending write
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]  w_ram_addr;
  logic [BYTES-1:0]  w_ram_be;
  logic [DATA_W-1:0] w_ram_wdata;

  always_comb begin
    w_ram_addr  = idx_a_q;
    w_ram_be    = '0;
    w_ram_wdata = new_a_q;
    case (state_q)
      RDB: w_ram_addr = idx_b_q;
      WRA: w_ram_be   = be_a_q;
      WRB: begin
        w_ram_addr  = idx_b_q;
        w_ram_be    = be_b_q;
        w_ram_wdata = new_b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (w_ram_be[i]) begin
        mem_q[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
      end
    end
    ram_dout_q <= mem_q[w_ram_addr];
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_a_q  <= '0;
      idx_b_q  <= '0;
      off_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      wdata_q  <= '0;
      span_q   <= 1'b0;
      sext_q   <= 1'b0;
      word_a_q <= '0;
      new_a_q  <= '0;
      new_b_q  <= '0;
      be_a_q   <= '0;
      be_b_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            idx_a_q <= w_idx_a;
            idx_b_q <= w_idx_b;
            off_q   <= w_off;
            we_q    <= we;
            size_q  <= size;
            wdata_q <= wdata;
            span_q  <= w_span;
            sext_q  <= w_sext;
            busy_q  <= 1'b1;
            if (size == 2'd3) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= RDA;
            end
          end
        end
        RDA: state_q <= span_q ? RDB : MRG;
        RDB: begin
          word_a_q <= ram_dout_q;
          state_q  <= MRG;
        end
        MRG: begin
          if (we_q) begin
            new_a_q <= w_merged[DATA_W-1:0];
            new_b_q <= w_merged[WIDE_W-1:DATA_W];
            be_a_q  <= w_mask_wide[BYTES-1:0];
            be_b_q  <= w_mask_wide[WB-1:BYTES];
            state_q <= WRA;
          end else begin
            rdata_q <= w_rd_final;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        WRA: begin
          if (span_q) begin
            state_q <= WRB;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        WRB: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_unaligned_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_unaligned_mem_ctrl
// Description : Self-checking bench for unaligned_mem_ctrl (DATA_W=32,
//               ADDR_W=12). A byte-array model predicts read data and the
//               accept-to-done latency of every access; a compare process
//               checks busy/done/err/rdata every cycle. Honours
//               MEM_SIGN_EXT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unaligned_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
`ifdef MEM_SIGN_EXT_EN
  logic        sext;
`endif

  unaligned_mem_ctrl #(.DATA_W(32), .ADDR_W(12)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .size  (size),
    .addr  (addr),
    .wdata (wdata),
`ifdef MEM_SIGN_EXT_EN
    .sext  (sext),
`endif
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Byte-addressed model of the whole RAM (4096 bytes)
  logic [7:0]  mdl [4096];

  // Handshake from the driver to the compare process
  bit          new_op = 1'b0;
  bit          cmp_en = 1'b0;
  int          op_lat;
  bit          op_err;
  bit          op_rd;
  logic [31:0] op_rdata;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [11:0] a, input logic [1:0] s, input bit sx);
    logic [31:0] r;
    int n;
    r = '0;
    n = nbytes(s);
    for (int i = 0; i < n; i++) r[8*i +: 8] = mdl[(int'(a) + i) % 4096];
    if (sx && n < 4 && r[8*n-1]) begin
      for (int i = 8*n; i < 32; i++) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Issue one access at a negedge, fill the busy window with random junk
  // requests that must be ignored, and return at the negedge where the DUT
  // is idle again.
  task automatic do_op(input bit w, input logic [1:0] s, input logic [11:0] a,
                       input logic [31:0] d, input bit sx,
                       output int lat_seen, output bit err_seen);
    int  n;
    int  lat;
    bit  span;
    n    = nbytes(s);
    span = ((int'(a) % 4) + n) > 4;
    if (s == 2'd3)  lat = 1;
    else if (!w)    lat = span ? 4 : 3;
    else            lat = span ? 6 : 4;
    op_lat   = lat;
    op_err   = (s == 2'd3);
    op_rd    = !w && (s != 2'd3);
    op_rdata = op_rd ? mdl_read(a, s, sx) : 32'h0;
    if (w && s != 2'd3) begin
      for (int i = 0; i < n; i++) mdl[(int'(a) + i) % 4096] = d[8*i +: 8];
    end
    req   = 1'b1;
    we    = w;
    size  = s;
    addr  = a;
    wdata = d;
`ifdef MEM_SIGN_EXT_EN
    sext  = sx;
`endif
    new_op   = 1'b1;
    lat_seen = 0;
    err_seen = 1'b0;
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (done && lat_seen == 0) begin
        lat_seen = j;
        err_seen = err;
      end
      req   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = 12'($urandom);
      wdata = $urandom;
`ifdef MEM_SIGN_EXT_EN
      sext  = 1'($urandom_range(0, 1));
`endif
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  // Per-cycle compare against the model's expectations
  initial begin : cmp
    int          k;
    int          lat;
    bit          act;
    bit          rd;
    bit          er;
    logic [31:0] er_rd;
    k = 0; lat = 0; act = 1'b0; rd = 1'b0; er = 1'b0; er_rd = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        act       = 1'b0;
        new_op    = 1'b0;
        exp_rdata = '0;
      end else if (cmp_en) begin
        if (new_op) begin
          new_op = 1'b0;
          act    = 1'b1;
          k      = 1;
          lat    = op_lat;
          rd     = op_rd;
          er     = op_err;
          er_rd  = op_rdata;
        end else if (act) begin
          k++;
        end
        if (act) begin
          chk("busy", 32'(busy), 32'(k <= lat));
          chk("done", 32'(done), 32'(k == lat));
          chk("err",  32'(err),  32'((k == lat) && er));
          if (k == lat && rd) exp_rdata = er_rd;
        end else begin
          chk("idle_busy", 32'(busy), 32'h0);
          chk("idle_done", 32'(done), 32'h0);
          chk("idle_err",  32'(err),  32'h0);
        end
        if (!(act && rd && k < lat)) chk("rdata", rdata, exp_rdata);
        if (act && k > lat) act = 1'b0;
      end
    end
  end

  initial begin : main
    int          lat;
    bit          es;
    logic [11:0] a;
    logic [1:0]  s;
    bit          w;
    bit          sx;
    int          r;

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; addr = '0; wdata = '0;
`ifdef MEM_SIGN_EXT_EN
    sext = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_err",   32'(err),  32'h0);
    chk("rst_rdata", rdata,     32'h0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Give every word a known value
    for (int i = 0; i < 1024; i++) do_op(1'b1, 2'd2, 12'(i*4), $urandom, 1'b0, lat, es);

    // Aligned word round trip with 3-cycle latency
    do_op(1'b1, 2'd2, 12'h004, 32'hAABBCCDD, 1'b0, lat, es);
    do_op(1'b0, 2'd2, 12'h004, 32'h0, 1'b0, lat, es);
    chk("word_rd_lat", 32'(lat), 32'd3);
    chk("word_rd",     rdata,    32'hAABBCCDD);

    // Spanning word read
    do_op(1'b1, 2'd2, 12'h000, 32'h03020100, 1'b0, lat, es);
    do_op(1'b1, 2'd2, 12'h004, 32'h07060504, 1'b0, lat, es);
    do_op(1'b0, 2'd2, 12'h003, 32'h0, 1'b0, lat, es);
    chk("span_rd_lat", 32'(lat), 32'd4);
    chk("span_rd",     rdata,    32'h06050403);

    // Single byte write preserves neighbours
    do_op(1'b1, 2'd0, 12'h005, 32'hFFFFFF5A, 1'b0, lat, es);
    do_op(1'b0, 2'd2, 12'h004, 32'h0, 1'b0, lat, es);
    chk("byte_merge", rdata, 32'h07065A04);

    // Halfword write wrapping from the top byte to byte 0
    do_op(1'b1, 2'd1, 12'hFFF, 32'h1234BEEF, 1'b0, lat, es);
    chk("wrap_wr_lat", 32'(lat), 32'd6);
    do_op(1'b0, 2'd0, 12'hFFF, 32'h0, 1'b0, lat, es);
    chk("wrap_lo", rdata, 32'h000000EF);
    do_op(1'b0, 2'd0, 12'h000, 32'h0, 1'b0, lat, es);
    chk("wrap_hi", rdata, 32'h000000BE);

    // Reserved size: immediate error, RAM untouched
    do_op(1'b1, 2'd2, 12'h010, 32'h12345678, 1'b0, lat, es);
    do_op(1'b1, 2'd3, 12'h010, 32'hFFFFFFFF, 1'b0, lat, es);
    chk("size3_lat", 32'(lat), 32'd1);
    chk("size3_err", 32'(es),  32'd1);
    do_op(1'b0, 2'd2, 12'h010, 32'h0, 1'b0, lat, es);
    chk("size3_ram", rdata, 32'h12345678);

`ifdef MEM_SIGN_EXT_EN
    do_op(1'b1, 2'd0, 12'h020, 32'h00000080, 1'b0, lat, es);
    do_op(1'b0, 2'd0, 12'h020, 32'h0, 1'b1, lat, es);
    chk("sext_byte", rdata, 32'hFFFFFF80);
`endif

    // Reset during WRA of a spanning write
    do_op(1'b1, 2'd2, 12'h100, 32'h11111111, 1'b0, lat, es);
    do_op(1'b1, 2'd2, 12'h104, 32'h22222222, 1'b0, lat, es);
    cmp_en = 1'b0;
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 12'h102; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("wra_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    // Word A may legally hold either value; restore it to a known one
    do_op(1'b1, 2'd2, 12'h100, 32'h11111111, 1'b0, lat, es);
    do_op(1'b0, 2'd2, 12'h104, 32'h0, 1'b0, lat, es);
    chk("abort_wordb", rdata, 32'h22222222);

    // Randomized traffic, biased towards word and memory boundaries
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      a = 12'(4092 + $urandom_range(0, 7));
      else if (r == 1) a = 12'(($urandom_range(0, 1023) * 4) + 3);
      else             a = 12'($urandom);
      r = $urandom_range(0, 15);
      s = (r == 0) ? 2'd3 : 2'(r % 3);
      w = 1'($urandom_range(0, 1));
`ifdef MEM_SIGN_EXT_EN
      sx = 1'($urandom_range(0, 1));
`else
      sx = 1'b0;
`endif
      do_op(w, s, a, $urandom, sx, lat, es);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
